bsk_prd_filt: RTL and testbench



---
 rtl/bsk_prd_filt.sv | 195 +++++++++++++++++++
 tb/tb_bsk_prd_filt.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bsk_prd_filt.sv
// Command-receiver board logic: debounced command inputs presented on the
// 16-bit host bus in nibble/complement format, indication outputs, a gated
// test frequency, a programmable filter length and a rising-edge event counter.
module bsk_prd_filt #(
    parameter logic [6:0] VERSION   = 7'h26,
    parameter logic [7:0] PASSWORD  = 8'hA4,
    parameter logic [3:0] CS        = 4'b1011,
    parameter int         CH_NUM    = 16,
    parameter int         CLOCK_IN  = 2_000_000,
    parameter int         TEST_FREQ = 250_000,
    parameter int         TICK_DIV  = 2000,
    parameter logic [3:0] FILT_DEF  = 4'd4
) (
    input  logic              clk,
    input  logic              iRes,
    inout  wire  [15:0]       bD,
    input  logic              iRd,
    input  logic              iWr,
    input  logic [2:0]        iA,
    input  logic [3:0]        iCS,
    input  logic              iBl,
    input  logic [CH_NUM-1:0] iCom,
    output logic [CH_NUM-1:0] oComInd,
    output logic              oCS,
    output logic              test
);

    localparam int          TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int          TDIV    = CLOCK_IN / TEST_FREQ / 2 - 1;
    localparam int          TDIV_W  = (TDIV > 0) ? $clog2(TDIV + 1) : 1;
    localparam logic [31:0] CH_MASK = (CH_NUM >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << CH_NUM) - 32'd1);

    // Synchronisers: [0] first stage, [1] synchronised value, [2] previous (edge detect)
    logic [2:0]             rd_sh_q, rd_sh_d, wr_sh_q, wr_sh_d;
    logic [1:0][2:0]        a_sync_q, a_sync_d;
    logic [1:0][3:0]        cs_sync_q, cs_sync_d;
    logic [1:0][CH_NUM-1:0] com_sync_q, com_sync_d;

    logic [CH_NUM-1:0]      f_q, f_d;
    logic [CH_NUM-1:0][3:0] cnt_q, cnt_d;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [31:0]            com_ind_q, com_ind_d;
    logic                   test_en_q, test_en_d;
    logic                   test_clk_q, test_clk_d;
    logic [TDIV_W-1:0]      tdiv_q, tdiv_d;
    logic [3:0]             filt_len_q, filt_len_d;
    logic [7:0]             evt_cnt_q, evt_cnt_d;
    logic [15:0]            data_bus_q, data_bus_d;

    logic        tick, rise, cs_hit, rd_evt, wr_evt;
    logic [2:0]  a_s;
    logic [4:0]  filt_eff;
    logic [31:0] f_ext;
    logic [3:0]  lo_nib, hi_nib;
    logic [15:0] rd_word;

    // Synchroniser shifts and host strobe event detection
    always_comb begin
        rd_sh_d    = {rd_sh_q[1:0], iRd};
        wr_sh_d    = {wr_sh_q[1:0], iWr};
        a_sync_d   = {a_sync_q[0], iA};
        cs_sync_d  = {cs_sync_q[0], iCS};
        com_sync_d = {com_sync_q[0], iCom};
        a_s        = a_sync_q[1];
        cs_hit     = (cs_sync_q[1] == CS);
        rd_evt     = rd_sh_q[2] & ~rd_sh_q[1] & cs_hit;
        // A simultaneous read takes priority; the write is dropped.
        wr_evt     = wr_sh_q[2] & ~wr_sh_q[1] & cs_hit & ~rd_evt;
    end

    // Register read multiplexer
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        f_ext              = '0;
        f_ext[CH_NUM-1:0]  = f_q;
        lo_nib             = f_ext[{a_s[1:0], 3'b000} +: 4];
        hi_nib             = f_ext[{a_s[1:0], 3'b100} +: 4];
        rd_word            = '0;
        case (a_s)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                // Words beyond the configured channel count read as all zero.
                if (int'(a_s) * 8 < CH_NUM)
                    rd_word = {~hi_nib, hi_nib, ~lo_nib, lo_nib};
            end
            3'd4:    rd_word = com_ind_q[15:0];
            3'd5:    rd_word = com_ind_q[31:16];
            3'd6:    rd_word = {PASSWORD, VERSION, test_en_q};
            default: rd_word = {evt_cnt_q, 3'b000, filt_len_q, test_en_q};
        endcase
    end

    // Tick prescaler and per-channel debounce filter
    always_comb begin
        tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        filt_eff   = (filt_len_q == 4'd0) ? 5'd1 : {1'b0, filt_len_q};
        f_d        = f_q;
        cnt_d      = cnt_q;
        if (tick) begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (com_sync_q[1][i] == f_q[i]) begin
                    cnt_d[i] = '0;
                end else if ({1'b0, cnt_q[i]} + 5'd1 >= filt_eff) begin
                    f_d[i]   = com_sync_q[1][i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
        rise = |(f_d & ~f_q);
    end

    // Host registers, event counter and read data latch
    always_comb begin
        com_ind_d  = com_ind_q;
        test_en_d  = test_en_q;
        filt_len_d = filt_len_q;
        evt_cnt_d  = evt_cnt_q;
        data_bus_d = data_bus_q;
        if (rise && evt_cnt_q != 8'hFF)
            evt_cnt_d = evt_cnt_q + 8'd1;
        if (rd_evt)
            data_bus_d = rd_word;
        if (wr_evt) begin
            case (a_s)
                3'd4: com_ind_d[15:0]  = bD & CH_MASK[15:0];
                3'd5: com_ind_d[31:16] = bD & CH_MASK[31:16];
                3'd6: test_en_d = bD[0];
                3'd7: begin
                    test_en_d  = bD[0];
                    filt_len_d = bD[4:1];
                    evt_cnt_d  = '0;
                end
                default: ;
            endcase
        end
    end

    // Test frequency divider: toggle on zero, then reload
    always_comb begin
        test_clk_d = test_clk_q;
        tdiv_d     = tdiv_q - 1'b1;
        if (tdiv_q == '0) begin
            tdiv_d     = TDIV_W'(TDIV);
            test_clk_d = ~test_clk_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!iRes) begin
            // NOTE: non-blocking assignments in clocked blocks keep every register sampling pre-edge values.
            rd_sh_q    <= '1;
            wr_sh_q    <= '1;
            a_sync_q   <= '0;
            cs_sync_q  <= '0;
            com_sync_q <= '0;
            f_q        <= '0;
            // NOTE: the counter array is reset explicitly; a stale count would shorten the first debounce.
            cnt_q      <= '0;
            tick_cnt_q <= '0;
            com_ind_q  <= '0;
            test_en_q  <= 1'b0;
            test_clk_q <= 1'b0;
            tdiv_q     <= TDIV_W'(TDIV);
            filt_len_q <= FILT_DEF;
            evt_cnt_q  <= '0;
            data_bus_q <= '0;
        end else begin
            rd_sh_q    <= rd_sh_d;
            wr_sh_q    <= wr_sh_d;
            a_sync_q   <= a_sync_d;
            cs_sync_q  <= cs_sync_d;
            com_sync_q <= com_sync_d;
            f_q        <= f_d;
            cnt_q      <= cnt_d;
            tick_cnt_q <= tick_cnt_d;
            com_ind_q  <= com_ind_d;
            test_en_q  <= test_en_d;
            test_clk_q <= test_clk_d;
            tdiv_q     <= tdiv_d;
            filt_len_q <= filt_len_d;
            evt_cnt_q  <= evt_cnt_d;
            data_bus_q <= data_bus_d;
        end
    end

    assign oCS     = (iCS != CS);
    assign bD      = (!iRd && iCS == CS) ? data_bus_q : 16'hzzzz;
    assign oComInd = ~com_ind_q[CH_NUM-1:0];
    assign test    = iBl & test_en_q & test_clk_q;

endmodule

// File: tb/tb_bsk_prd_filt.sv
// Directed bench for bsk_prd_filt: reset state, host register map, debounce
// filter latency and glitch rejection, indication, test output and event counter.
module tb_bsk_prd_filt;

    localparam logic [3:0] CS = 4'b1011;
    localparam int         TD = 20;

    logic        clk = 1'b0;
    logic        iRes, iRd, iWr, iBl;
    logic [2:0]  iA;
    logic [3:0]  iCS;
    logic [15:0] iCom;
    wire  [15:0] bD;
    logic [15:0] oComInd;
    logic        oCS, test;
    logic        drv_en;
    logic [15:0] drv_val;
    logic [15:0] rd;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic        prev, found, seen;

    assign bD = drv_en ? drv_val : 16'hzzzz;

    bsk_prd_filt #(.TICK_DIV(TD)) dut (
        .clk(clk), .iRes(iRes), .bD(bD), .iRd(iRd), .iWr(iWr), .iA(iA),
        .iCS(iCS), .iBl(iBl), .iCom(iCom), .oComInd(oComInd), .oCS(oCS), .test(test)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the DUT tick fires on edges where cyc % TD == 0.
    always @(posedge clk) begin
        if (!iRes) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic host_read(input logic [2:0] a, output logic [15:0] d);
        iA  = a;
        iRd = 1'b0;
        repeat (4) @(negedge clk);
        d   = bD;
        iRd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic host_write(input logic [2:0] a, input logic [15:0] d);
        iA      = a;
        drv_val = d;
        drv_en  = 1'b1;
        iWr     = 1'b0;
        repeat (5) @(negedge clk);
        iWr     = 1'b1;
        repeat (3) @(negedge clk);
        drv_en  = 1'b0;
    endtask

    initial begin
        iRes = 1'b0; iRd = 1'b1; iWr = 1'b1; iBl = 1'b1; iA = '0; iCS = CS;
        iCom = '0; drv_en = 1'b0; drv_val = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_comind", oComInd, 16'hFFFF);
        check("rst_test", test, 0);
        check("ocs_hit", oCS, 0);
        iCS = 4'b0000;
        #1 check("ocs_miss", oCS, 1);
        iCS = CS;
        @(negedge clk);
        iRes = 1'b1;
        repeat (3) @(negedge clk);
        host_read(3'd7, rd); check("rst_a7", rd, 16'h0008);
        host_read(3'd6, rd); check("rst_a6", rd, 16'hA44C);
        host_read(3'd0, rd); check("rst_a0", rd, 16'hF0F0);
        host_read(3'd1, rd); check("rst_a1", rd, 16'hF0F0);
        host_read(3'd2, rd); check("a2_beyond_ch", rd, 16'h0000);

        // Filter latency on channel 0 (filt_len 4)
        iCom[0] = 1'b1;
        repeat (2 * TD) @(negedge clk);
        host_read(3'd0, rd); check("filt_early", rd, 16'hF0F0);
        repeat (3 * TD) @(negedge clk);
        host_read(3'd0, rd); check("filt_done", rd, 16'hF0E1);
        host_read(3'd7, rd); check("evt_one", rd, 16'h0108);

        // Two-tick glitch on channel 5 is rejected
        iCom[5] = 1'b1;
        repeat (2 * TD) @(negedge clk);
        iCom[5] = 1'b0;
        repeat (3 * TD) @(negedge clk);
        host_read(3'd0, rd); check("glitch_a0", rd, 16'hF0E1);

        // Indication registers
        host_write(3'd4, 16'hA5A5);
        check("ind_out", oComInd, 16'h5A5A);
        host_read(3'd4, rd); check("ind_a4", rd, 16'hA5A5);
        host_write(3'd5, 16'hFFFF);
        host_read(3'd5, rd); check("ind_a5", rd, 16'h0000);

        // Test output: period 8 clk, blocked by iBl
        host_write(3'd6, 16'h0001);
        found = 1'b0;
        prev  = test;
        for (int i = 0; i < 24 && !found; i++) begin
            @(negedge clk);
            if (!prev && test) found = 1'b1;
            prev = test;
        end
        check("test_rise_found", found, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("test_phase_%0d", k), test, (k < 4 || k == 8) ? 1 : 0);
        end
        iBl = 1'b0;
        #1 check("test_blocked", test, 0);
        iBl = 1'b1;
        @(negedge clk);
        host_read(3'd6, rd); check("a6_test_en", rd, 16'hA44D);

        // Control register
        host_write(3'd7, 16'h0003);
        host_read(3'd7, rd); check("ctrl_a7", rd, 16'h0003);

        // Event counter saturation with filt_len 1
        for (int n = 0; n < 260; n++) begin
            iCom[2] = 1'b1;
            repeat (TD) @(negedge clk);
            iCom[2] = 1'b0;
            repeat (TD) @(negedge clk);
        end
        host_read(3'd7, rd); check("evt_sat", rd, 16'hFF03);

        // Control write lands on the same edge as an f rising edge
        found = 1'b0;
        for (int i = 0; i < TD + 2 && !found; i++) begin
            if (cyc % TD == TD - 3) found = 1'b1;
            else @(negedge clk);
        end
        check("tick_align", found, 1);
        iCom[2] = 1'b1;
        host_write(3'd7, 16'h0003);
        host_read(3'd7, rd); check("evt_write_wins", rd, 16'h0003);
        host_read(3'd0, rd); check("f_ch2", rd, 16'hF0A5);

        // Reset mid-operation: read window open, channel 7 mid-count
        host_write(3'd7, 16'h0009);
        iCom[7] = 1'b1;
        repeat (2 * TD) @(negedge clk);
        iA  = 3'd7;
        iRd = 1'b0;
        repeat (4) @(negedge clk);
        iRes = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_bus", bD, 16'h0000);
        check("mid_rst_comind", oComInd, 16'hFFFF);
        iRes = 1'b1;
        iRd  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | test;
        end
        check("mid_rst_test", seen, 0);
        repeat (2 * TD - 14) @(negedge clk);
        host_read(3'd0, rd); check("rebuild_early", rd, 16'hF0F0);
        host_read(3'd7, rd); check("rebuild_a7", rd, 16'h0008);
        repeat (3 * TD) @(negedge clk);
        host_read(3'd0, rd); check("rebuild_done", rd, 16'h78A5);
        host_read(3'd7, rd); check("rebuild_evt", rd, 16'h0108);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
